entrada_io_debounce: RTL

- Input-conditioning stage directly upstream of the CPU's IN path.
- Takes the raw board push button and 4-bit switch bank, then synchronises, debounces and edge-detects the button.
- On each confirmed press, snapshots the switches into a holding register.
- Presents the snapshot with a valid/consume handshake, so each IN instruction reads exactly one press.

---
 rtl/entrada_io_debounce_if.sv | 24 ++
 rtl/entrada_io_debounce.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/entrada_io_debounce_if.sv
// CPU-side capture handshake for entrada_io_debounce: the held switch snapshot
// plus its valid/consume/overwrite flags.
interface entrada_io_debounce_if #(
   parameter int DATA_W = 4
);
   logic              consumir;
   logic              dado_valido;
   logic [DATA_W-1:0] dado_capturado;
   logic              sobrescrita;

   modport master (
      input  consumir,
      output dado_valido,
      output dado_capturado,
      output sobrescrita
   );

   modport slave (
      output consumir,
      input  dado_valido,
      input  dado_capturado,
      input  sobrescrita
   );
endinterface

// File: rtl/entrada_io_debounce.sv
// Button/switch conditioning for the CPU IN path: synchronise, debounce, snapshot on press.
// Optional auto-repeat while the button is held: define INPUT_AUTOREPEAT_EN.
module entrada_io_debounce #(
   parameter int DEBOUNCE_CYCLES   = 50000,
   parameter int DATA_W            = 4,
   parameter bit BUTTON_ACTIVE_LOW = 1'b1
`ifdef INPUT_AUTOREPEAT_EN
   ,
   parameter int REPEAT_DELAY      = 25000000,
   parameter int REPEAT_RATE       = 10000000
`endif
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       botao_raw,
   input  logic [DATA_W-1:0]          dados_raw,
   output logic                       botao_limpo,
   output logic                       pulso_botao,
   entrada_io_debounce_if.master      cpu
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   // Accept on the edge where the count would reach DEBOUNCE_CYCLES-1.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

`ifdef INPUT_AUTOREPEAT_EN
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] HOLD_FIRST = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] HOLD_NEXT  = HOLD_W'(REPEAT_RATE - 1);
`endif

   typedef enum logic [1:0] {
      SOLTO,
      CONF_PRESS,
      PRESSIONADO,
      CONF_SOLTA
   } estado_t;

   logic              btn_norm;
   logic              btn_s1_q;
   logic              btn_s2_q;
   logic [DATA_W-1:0] sw_s1_q;
   logic [DATA_W-1:0] sw_s2_q;

   estado_t           estado_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              limpo_q;
   logic              pulso_q;
`ifdef INPUT_AUTOREPEAT_EN
   logic [HOLD_W-1:0] hold_q;
   logic              repetindo_q;
`endif

   logic              valido_q;
   logic              valido_d;
   logic [DATA_W-1:0] dado_q;
   logic [DATA_W-1:0] dado_d;
   logic              sobre_q;
   logic              sobre_d;

   assign btn_norm = BUTTON_ACTIVE_LOW ? ~botao_raw : botao_raw;

   // ---- stage: two-flop synchronisers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
         sw_s1_q  <= '0;
         sw_s2_q  <= '0;
      end else begin
         btn_s1_q <= btn_norm;
         btn_s2_q <= btn_s1_q;
         sw_s1_q  <= dados_raw;
         sw_s2_q  <= sw_s1_q;
      end
   end

   // ---- stage: debounce FSM with registered level and press pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q    <= SOLTO;
         cnt_q       <= '0;
         limpo_q     <= 1'b0;
         pulso_q     <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
         hold_q      <= '0;
         repetindo_q <= 1'b0;
`endif
      end else begin
         pulso_q <= 1'b0;
`ifdef INPUT_AUTOREPEAT_EN
         hold_q      <= '0;
         repetindo_q <= 1'b0;
`endif
         case (estado_q)
            SOLTO: begin
               if (btn_s2_q) begin
                  estado_q <= CONF_PRESS;
                  cnt_q    <= '0;
               end
            end
            CONF_PRESS: begin
               if (!btn_s2_q) begin
                  estado_q <= SOLTO;
               end else if (cnt_q == CNT_LAST) begin
                  estado_q <= PRESSIONADO;
                  limpo_q  <= 1'b1;
                  pulso_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            PRESSIONADO: begin
               if (!btn_s2_q) begin
                  estado_q <= CONF_SOLTA;
                  cnt_q    <= '0;
               end
`ifdef INPUT_AUTOREPEAT_EN
               // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE.
               else if (hold_q == (repetindo_q ? HOLD_NEXT : HOLD_FIRST)) begin
                  pulso_q     <= 1'b1;
                  hold_q      <= '0;
                  repetindo_q <= 1'b1;
               end else begin
                  hold_q      <= hold_q + 1'b1;
                  repetindo_q <= repetindo_q;
               end
`endif
            end
            CONF_SOLTA: begin
               if (btn_s2_q) begin
                  estado_q <= PRESSIONADO;
               end else if (cnt_q == CNT_LAST) begin
                  estado_q <= SOLTO;
                  limpo_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: estado_q <= SOLTO;
         endcase
      end
   end

   // A press that coincides with a consume replaces the old value cleanly.
   always_comb begin
      valido_d = valido_q;
      dado_d   = dado_q;
      sobre_d  = sobre_q;
      if (pulso_q) begin
         if (!valido_q || cpu.consumir) begin
            valido_d = 1'b1;
            dado_d   = sw_s2_q;
            sobre_d  = 1'b0;
         end else begin
            sobre_d  = 1'b1;
         end
      end else if (cpu.consumir && valido_q) begin
         valido_d = 1'b0;
         sobre_d  = 1'b0;
      end
   end

   // ---- stage: holding register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valido_q <= 1'b0;
         dado_q   <= '0;
         sobre_q  <= 1'b0;
      end else begin
         valido_q <= valido_d;
         dado_q   <= dado_d;
         sobre_q  <= sobre_d;
      end
   end

   assign botao_limpo        = limpo_q;
   assign pulso_botao        = pulso_q;
   assign cpu.dado_valido    = valido_q;
   assign cpu.dado_capturado = dado_q;
   assign cpu.sobrescrita    = sobre_q;

endmodule
